i2c_slave_regfile: RTL
======================

# i2c_slave_regfile

I2C slave endpoint with a small internal register file; it is the stage directly downstream of the I2C master on the shared `i2c_i` bus. It consumes the master's `scl`/`sda_out` and drives its own open-drain contribution back on `sda_in`. All logic runs in the `clk100mhz` domain, oversampling SCL/SDA. Write transactions update the register file. Read transactions return register contents MSB first.

## Interface
Parameters:
- `SLV_ADDR` — 5'h15 — 5-bit slave address, compared against bits [7:3] of the address byte
- `NREG` — 16 — number of 8-bit registers; power of two, 2..256
- `PW` — $clog2(NREG) — register pointer width (derived)

Ports:
- `clk100mhz`  in  1  system clock, 100 MHz
- `res`  in  1  reset; asynchronous, active-low
- `scl`  in  1  I2C clock from master
- `sda_out`  in  1  master's SDA drive; 1 = released
- `sda_in`  out  1  slave's SDA drive; 1 = released, 0 = pull low; reset 1
- `rd_addr`  in  PW  local read-port index
- `rd_data`  out  8  combinational `regs[rd_addr]`
- `reg_wr_stb`  out  1  one-cycle pulse per register write; reset 0
- `reg_wr_addr`  out  PW  index written; valid with strobe; reset 0
- `reg_wr_data`  out  8  byte written; valid with strobe; reset 0
- `busy`  out  1  high from START to STOP while addressed; reset 0

## Operation
- Bus line sensed as `sda_bus = sda_out & sda_in` (wired-AND). `scl` and `sda_bus` each pass through a 2-flop synchronizer, then a 1-flop edge detector.
- START: sda_bus falls while scl high. STOP: sda_bus rises while scl high. Both are valid in any state, including mid-byte.
- START goes to ADDR and clears the bit counter. STOP goes to IDLE and releases `sda_in`.
- Data bits are sampled on synchronized SCL rise. `sda_in` changes only on synchronized SCL fall.
- Address byte: [7:3] = address, [2:1] = don't care, [0] = rw (1 = read).
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Match → ADDR_ACK.
    - Mismatch → IGNORE; never drive SDA, hold until START/STOP.
  - ADDR_ACK: drive 0 for the 9th bit.
    - Then REG if rw=0.
    - Then RDATA if rw=1; load shifter with `regs[ptr]`.
  - REG: shift byte; `ptr <= byte[PW-1:0]` (upper bits ignored) → REG_ACK → WDATA.
  - WDATA: shift byte → WDATA_ACK.
    - Write `regs[ptr]`, pulse `reg_wr_stb`, ACK.
    - Advance ptr per Configuration.
    - Loop to WDATA.
  - RDATA: drive shifter MSB first → RDATA_ACK; release SDA and sample master.
    - ACK (0): advance ptr, reload, → RDATA.
    - NACK (1): → IGNORE.
- Pointer arithmetic is modulo NREG: NREG-1 wraps to 0.
- Register contents persist across transactions; only `res` clears them.
- Repeated START: aborts any partial byte without a write. Pointer is kept, so a write of the reg byte followed by a repeated-START read returns `regs[ptr]`.

## Timing
- Sense latency: 3 `clk100mhz` cycles from a pin edge to the detected event.
- `sda_in` updates 4 cycles after an SCL pin fall.
- Required bus timing: SCL high ≥ 6 cycles and SCL low ≥ 8 cycles; SDA setup to SCL rise ≥ 4 cycles.
- `reg_wr_stb` is high exactly one cycle: the cycle after the 8th data-bit sample. The register updates on that same edge.
- `busy` rises 1 cycle after address match is sampled; falls 1 cycle after STOP or NACK is detected.
- Reset asserted mid-transaction: immediately all registers 0, `ptr` 0, state IDLE, `sda_in` 1, strobes 0. After release, the block ignores the bus until the next START.
- Simultaneous START and STOP detection is impossible; STOP has priority if encoding allows.

## Configuration
- `I2C_SLV_AUTOINC_EN` defined: `ptr` increments (mod NREG) after every written byte and after every read byte that is ACKed.
- Not defined: `ptr` changes only in REG. Successive data bytes rewrite, and successive reads return, the same register.

## Test plan
- Write, SLV_ADDR=5'h15: START, 8'hA8, 8'h03, 8'h5C, STOP → slave ACKs all three bytes; `reg_wr_stb` pulses once with addr 3, data 8'h5C; `rd_addr=3` gives `rd_data=8'h5C`.
- Read: after the write above, START, A8, 03, repeated START, A9, master NACK, STOP → slave ACKs; drives 8'h5C MSB first; `sda_in` = 1 after NACK; `busy` falls.
- Address mismatch: START, 8'h50, 8'h01, 8'hFF, STOP → `sda_in` stays 1 throughout; no strobe; registers unchanged.
- Auto-increment wrap: START, A8, 8'h0F, 8'h11, 8'h22, STOP.
  - With macro: reg15 = 8'h11 and reg0 = 8'h22.
  - Without macro: reg15 = 8'h22 and reg0 unchanged.
- Reset mid-byte: assert `res`=0 after 4 data bits of a write → `sda_in`=1 and all registers 0 immediately. A following full transaction behaves as in the first write scenario.
- STOP mid-byte: STOP after 5 bits of data byte → no strobe; state IDLE; `busy`=0.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C slave with an NREG x 8 register file, oversampling scl/sda on clk100mhz.
// Ports: clk100mhz, res (async low), scl, sda_out in; sda_in out; rd_addr/rd_data
// local read port; reg_wr_stb/addr/data write notify; busy. Macro: I2C_SLV_AUTOINC_EN.
module i2c_slave_regfile #(
  parameter logic [4:0] SLV_ADDR = 5'h15,
  parameter int NREG = 16,
  parameter int PW = $clog2(NREG)
) (
  input  logic          clk100mhz,
  input  logic          res,
  input  logic          scl,
  input  logic          sda_out,
  output logic          sda_in,
  input  logic [PW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          reg_wr_stb,
  output logic [PW-1:0] reg_wr_addr,
  output logic [7:0]    reg_wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t state, nxt;

  logic [7:0]    regs [NREG];
  logic [1:0]    scl_sy, sda_sy;
  logic          scl_d, sda_d;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic [PW-1:0] ptr, pinc;
  logic          ph, rw, sda_nxt;

  wire sda_bus  = sda_out & sda_in;
  wire scl_s    = scl_sy[1];
  wire sda_s    = sda_sy[1];
  wire scl_rise = scl_s & ~scl_d;
  wire scl_fall = ~scl_s & scl_d;
  wire start    = scl_s & scl_d & sda_d & ~sda_s;
  wire stop     = scl_s & scl_d & ~sda_d & sda_s;
  wire last     = scl_rise && (bitcnt == 3'd7);
  wire [7:0] shin = {shreg[6:0], sda_s};
  wire addr_hit = (shin[7:3] == SLV_ADDR);

`ifdef I2C_SLV_AUTOINC_EN
  assign pinc = ptr + PW'(1);
`else
  assign pinc = ptr;
`endif

  assign rd_data = regs[rd_addr];

  always_ff @(posedge clk100mhz or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (stop) nxt = IDLE;
    else if (start) nxt = ADDR;
    else begin
      unique case (state)
        ADDR:      if (last) nxt = addr_hit ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (scl_fall && ph) nxt = rw ? RDATA : REG;
        REG:       if (last) nxt = REG_ACK;
        REG_ACK:   if (scl_fall && ph) nxt = WDATA;
        WDATA:     if (last) nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall && ph) nxt = WDATA;
        RDATA:     if (last) nxt = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && ph && sda_s) nxt = IGNORE;
          else if (scl_fall && ph) nxt = RDATA;
        end
        default: ;
      endcase
    end
  end

  // ACK states: first SCL fall pulls low, second fall ends the 9th bit.
  always_comb begin
    sda_nxt = sda_in;
    if (stop || start) sda_nxt = 1'b1;
    else if (scl_fall) begin
      unique case (state)
        ADDR_ACK:  sda_nxt = ph ? (rw ? regs[ptr][7] : 1'b1) : 1'b0;
        REG_ACK:   sda_nxt = ph;
        WDATA_ACK: sda_nxt = ph;
        RDATA:     sda_nxt = shreg[6];
        RDATA_ACK: sda_nxt = ph ? regs[pinc][7] : 1'b1;
        default:   sda_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk100mhz or negedge res) begin
    if (!res) begin
      scl_sy      <= 2'b11;
      sda_sy      <= 2'b11;
      scl_d       <= 1'b1;
      sda_d       <= 1'b1;
      sda_in      <= 1'b1;
      shreg       <= '0;
      bitcnt      <= '0;
      ptr         <= '0;
      ph          <= 1'b0;
      rw          <= 1'b0;
      busy        <= 1'b0;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      scl_sy     <= {scl_sy[0], scl};
      sda_sy     <= {sda_sy[0], sda_bus};
      scl_d      <= scl_s;
      sda_d      <= sda_s;
      sda_in     <= sda_nxt;
      reg_wr_stb <= 1'b0;
      if (stop) begin
        busy <= 1'b0;
        ph   <= 1'b0;
      end else if (start) begin
        bitcnt <= '0;
        ph     <= 1'b0;
      end else begin
        unique case (state)
          ADDR: if (scl_rise) begin
            shreg  <= shin;
            bitcnt <= bitcnt + 3'd1;
            if (last) begin
              rw   <= sda_s;
              busy <= addr_hit;
            end
          end
          REG: if (scl_rise) begin
            shreg  <= shin;
            bitcnt <= bitcnt + 3'd1;
            if (last) ptr <= shin[PW-1:0];
          end
          WDATA: if (scl_rise) begin
            shreg  <= shin;
            bitcnt <= bitcnt + 3'd1;
            if (last) begin
              regs[ptr]   <= shin;
              reg_wr_stb  <= 1'b1;
              reg_wr_addr <= ptr;
              reg_wr_data <= shin;
              ptr         <= pinc;
            end
          end
          ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
            ph <= ~ph;
            if (ph && state == ADDR_ACK && rw) shreg <= regs[ptr];
          end
          RDATA: begin
            if (scl_rise) bitcnt <= bitcnt + 3'd1;
            if (scl_fall) shreg <= {shreg[6:0], 1'b0};
          end
          RDATA_ACK: begin
            if (scl_rise && ph && sda_s) begin
              busy <= 1'b0;
              ph   <= 1'b0;
            end else if (scl_fall) begin
              ph <= ~ph;
              if (ph) begin
                ptr   <= pinc;
                shreg <= regs[pinc];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
